// File: rtl/emif_tx_reg.sv
// EMIF read-side responder: synchronizes DSP read strobes, fetches a register-file word
// and drives one 16-bit half onto the pad bus. Optional feature macro: EMIF_TX_SHADOW_EN.
module emif_tx_reg #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int SYNC_STEPS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    emif_cs_n_i,
    input  logic                    emif_oe_n_i,
    input  logic [ADDR_WIDTH-1:0]   emif_addr_i,
    output logic                    rd_en_o,
    output logic [ADDR_WIDTH-2:0]   rd_addr_o,
    input  logic [2*WIDTH-1:0]      rd_data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    data_oe_o,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_DRIVE,
        S_RELEASE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SYNC_STEPS-1:0]   r_cs_sync;
    logic [SYNC_STEPS-1:0]   r_oe_sync;
    logic [ADDR_WIDTH-1:0]   r_addr_sync [SYNC_STEPS];

    logic                    r_rd_en;
    logic [ADDR_WIDTH-2:0]   r_rd_addr;
    logic                    r_half;
    logic [WIDTH-1:0]        r_data;
    logic                    r_data_oe;

    logic                    w_cs_s;
    logic                    w_oe_s;
    logic [ADDR_WIDTH-1:0]   w_addr_s;
    logic                    w_strobe;
    logic                    w_latch;
    logic                    w_fetch;
    logic                    w_capture;
    logic                    w_release;
    logic [WIDTH-1:0]        w_cap_data;

    // Strobes idle high after reset so no access is seen until the pins really go low.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cs_sync <= '1;
            r_oe_sync <= '1;
            // NOTE: a small flop array like this synchronizer chain may be reset in a loop; large RAM-style arrays should not be.
            for (int i = 0; i < SYNC_STEPS; i++) r_addr_sync[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value, forming a true shift chain.
            r_cs_sync      <= {r_cs_sync[SYNC_STEPS-2:0], emif_cs_n_i};
            r_oe_sync      <= {r_oe_sync[SYNC_STEPS-2:0], emif_oe_n_i};
            r_addr_sync[0] <= emif_addr_i;
            for (int i = 1; i < SYNC_STEPS; i++) r_addr_sync[i] <= r_addr_sync[i-1];
        end
    end

    assign w_cs_s   = r_cs_sync[SYNC_STEPS-1];
    assign w_oe_s   = r_oe_sync[SYNC_STEPS-1];
    assign w_addr_s = r_addr_sync[SYNC_STEPS-1];
    assign w_strobe = !w_cs_s && !w_oe_s;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: defaulting the next state first keeps this block free of inferred latches.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_strobe) w_state_nxt = S_FETCH;
            S_FETCH:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_DRIVE;
            S_DRIVE:   if (w_cs_s || w_oe_s) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch   = (r_state == S_IDLE) && w_strobe;
        w_fetch   = (r_state == S_FETCH);
        w_capture = (r_state == S_CAPTURE);
        w_release = (r_state == S_RELEASE);
        busy_o    = (r_state != S_IDLE);
    end

`ifdef EMIF_TX_SHADOW_EN
    logic [WIDTH-1:0] r_shadow;

    // Low-half reads snapshot the upper half so a following high-half read is coherent.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)                  r_shadow <= '0;
        else if (w_capture && !r_half) r_shadow <= rd_data_i[2*WIDTH-1:WIDTH];
    end

    assign w_cap_data = r_half ? r_shadow : rd_data_i[WIDTH-1:0];
`else
    assign w_cap_data = r_half ? rd_data_i[2*WIDTH-1:WIDTH] : rd_data_i[WIDTH-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_half    <= 1'b0;
            r_data    <= '0;
            r_data_oe <= 1'b0;
        end else begin
            r_rd_en <= w_fetch;
            if (w_latch) {r_rd_addr, r_half} <= w_addr_s;
            if (w_capture) begin
                r_data    <= w_cap_data;
                r_data_oe <= 1'b1;
            end else if (w_release) begin
                r_data_oe <= 1'b0;
            end
        end
    end

    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_rd_addr;
    assign data_o    = r_data;
    assign data_oe_o = r_data_oe;

endmodule

// File: tb/tb_emif_tx_reg.sv
// Self-checking bench for emif_tx_reg: directed and randomized EMIF reads checked against
// a transaction-level register-file / half-select model.
module tb_emif_tx_reg;

    localparam int WIDTH = 16;
    localparam int AW    = 8;
    localparam int SYNC  = 2;
`ifdef EMIF_TX_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              emif_cs_n_i;
    logic              emif_oe_n_i;
    logic [AW-1:0]     emif_addr_i;
    logic              rd_en_o;
    logic [AW-2:0]     rd_addr_o;
    logic [2*WIDTH-1:0] rd_data_i;
    logic [WIDTH-1:0]  data_o;
    logic              data_oe_o;
    logic              busy_o;

    emif_tx_reg #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .SYNC_STEPS(SYNC)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .emif_cs_n_i (emif_cs_n_i),
        .emif_oe_n_i (emif_oe_n_i),
        .emif_addr_i (emif_addr_i),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .data_o      (data_o),
        .data_oe_o   (data_oe_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Register-file model and shadow model.
    logic [31:0] mem [128];
    logic [15:0] shadow_m = '0;

    // Monitor state, sampled on the falling edge.
    int          cyc = 0;
    int          rd_en_cnt = 0;
    int          last_en_cyc = -100;
    logic [6:0]  last_rd_addr = '0;
    logic        prev_rd_en = 1'b0;
    logic        prev_oe = 1'b0;
    int          oe_rise_cyc = 0;
    int          oe_fall_cyc = 0;
    logic [15:0] cap_data = '0;
    int          overhang = 0;
    int          max_overhang = 0;
    bit          check_spacing = 1'b0;

    always @(negedge clk_i) begin
        cyc++;
        if (rd_en_o) begin
            rd_en_cnt++;
            last_rd_addr = rd_addr_o;
            check("rd_en_width", {31'd0, prev_rd_en}, 32'd0);
            check("fetch_while_driving", {31'd0, data_oe_o}, 32'd0);
            if (check_spacing && last_en_cyc > 0)
                check("rd_en_spacing_ge5", {31'd0, (cyc - last_en_cyc) >= 5}, 32'd1);
            last_en_cyc = cyc;
            rd_data_i = mem[rd_addr_o];
        end else begin
            rd_data_i = $urandom;
        end
        if (data_oe_o && !prev_oe) begin
            oe_rise_cyc = cyc;
            cap_data    = data_o;
        end else if (data_oe_o) begin
            check("data_stable", {16'd0, data_o}, {16'd0, cap_data});
        end
        if (!data_oe_o && prev_oe) oe_fall_cyc = cyc;
        if (data_oe_o && emif_oe_n_i) overhang++;
        else overhang = 0;
        if (overhang > max_overhang) max_overhang = overhang;
        prev_rd_en = rd_en_o;
        prev_oe    = data_oe_o;
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    // One complete read: strobe low for 'hold' clocks, then wait for the bus to be released.
    task automatic do_read(input logic [7:0] a, input int hold, input bit keep_cs);
        int          n0, t0, t1;
        bit          done;
        logic [15:0] exp;
        logic [31:0] word;
        word = mem[a[7:1]];
        if (!a[0]) begin
            exp      = word[15:0];
            shadow_m = word[31:16];
        end else begin
            exp = SHADOW ? shadow_m : word[31:16];
        end
        n0 = rd_en_cnt;
        tick();
        emif_addr_i = a;
        emif_cs_n_i = 1'b0;
        emif_oe_n_i = 1'b0;
        t0 = cyc;
        repeat (hold) tick();
        emif_oe_n_i = 1'b1;
        if (!keep_cs) emif_cs_n_i = 1'b1;
        t1 = cyc;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (oe_fall_cyc > t1 && !busy_o) done = 1'b1;
        end
        check("release_timeout", {31'd0, done}, 32'd1);
        check("rd_en_count", rd_en_cnt - n0, 32'd1);
        check("rd_addr", {25'd0, last_rd_addr}, {25'd0, a[7:1]});
        check("data", {16'd0, cap_data}, {16'd0, exp});
        check("drive_latency", {31'd0, (oe_rise_cyc > t0) && (oe_rise_cyc - t0 <= SYNC + 3)}, 32'd1);
        check("release_latency", {31'd0, oe_fall_cyc - t1 <= SYNC + 2}, 32'd1);
    endtask

    initial begin
        int          n0, t0;
        bit          done;
        logic [15:0] outs;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        rst_n_i     = 1'b0;
        emif_cs_n_i = 1'b1;
        emif_oe_n_i = 1'b1;
        emif_addr_i = '0;
        rd_data_i   = '0;
        repeat (4) tick();
        check("reset_outputs", {data_o, 7'd0, rd_en_o, data_oe_o, busy_o, rd_addr_o != 0}, 32'd0);
        rst_n_i = 1'b1;

        // Idle after reset: nothing may move for 100 clocks.
        outs = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            outs = outs | data_o | {12'd0, rd_en_o, data_oe_o, busy_o, rd_addr_o != 0};
        end
        check("idle_100_clocks", {16'd0, outs}, 32'd0);
        check("idle_no_fetch", rd_en_cnt, 32'd0);

        // Single read of the low half, then coherent high-half read.
        mem[3] = 32'hBEEF_1234;
        do_read(8'h06, 8, 1'b0);
        check("single_read_low", {16'd0, cap_data}, 32'h1234);
        mem[3] = 32'hAAAA_5555;
        do_read(8'h07, 8, 1'b0);
        check("shadow_coherence", {16'd0, cap_data}, SHADOW ? 32'hBEEF : 32'hAAAA);

        // Long held strobe: one fetch only, data stable while rd_data_i toggles.
        do_read(8'h06, 50, 1'b0);

        // Back-to-back reads with cs_n held low, oe_n pulsed.
        check_spacing = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_read(8'($urandom_range(0, 255)), $urandom_range(7, 10), 1'b1);
        end
        emif_cs_n_i   = 1'b1;
        check_spacing = 1'b0;

        // One-clock oe_n glitch: at most one complete fetch/release.
        n0 = rd_en_cnt;
        tick();
        emif_addr_i = 8'h20;
        emif_cs_n_i = 1'b0;
        emif_oe_n_i = 1'b0;
        tick();
        emif_oe_n_i = 1'b1;
        emif_cs_n_i = 1'b1;
        repeat (15) tick();
        check("glitch_fetch_le1", {31'd0, (rd_en_cnt - n0) <= 1}, 32'd1);
        check("glitch_released", {30'd0, data_oe_o, busy_o}, 32'd0);
        // A low-half glitch fetch still refreshes the shadow.
        if (rd_en_cnt != n0) shadow_m = mem[8'h20 >> 1][31:16];

        // Reset asserted while the bus is being driven.
        tick();
        emif_addr_i = 8'h10;
        emif_cs_n_i = 1'b0;
        emif_oe_n_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (data_oe_o) done = 1'b1;
        end
        check("drive_before_reset", {31'd0, done}, 32'd1);
        rst_n_i = 1'b0;
        n0 = rd_en_cnt;
        tick();
        check("reset_mid_drive", {30'd0, data_oe_o, busy_o}, 32'd0);
        emif_cs_n_i = 1'b1;
        emif_oe_n_i = 1'b1;
        repeat (3) tick();
        check("reset_no_fetch", rd_en_cnt - n0, 32'd0);
        check("reset_data_cleared", {16'd0, data_o}, 32'd0);
        shadow_m = '0;
        rst_n_i  = 1'b1;
        repeat (5) tick();
        // High-half read straight after reset exposes the cleared shadow.
        do_read(8'h11, 8, 1'b0);

        // Randomized reads with occasional register-file updates between them.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 127)] = $urandom;
            do_read(8'($urandom_range(0, 255)), $urandom_range(7, 14), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Write-type access (cs low, oe high) must be ignored.
        n0 = rd_en_cnt;
        tick();
        emif_cs_n_i = 1'b0;
        repeat (12) tick();
        emif_cs_n_i = 1'b1;
        repeat (4) tick();
        check("cs_only_ignored", rd_en_cnt - n0, 32'd0);

        check("oe_overhang_max", {31'd0, max_overhang <= SYNC + 2}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
